// File: rtl/pad_config_loader.sv
// Pad configuration store and dual serial-chain loader: holds one word per pad and
// shifts a snapshot out on two chains, then pulses serial_load to latch them.
module pad_config_loader #(
    parameter int                  AREA1PADS   = 14,
    parameter int                  TOTAL_PADS  = 27,
    parameter int                  CFG_BITS    = 13,
    parameter int                  CLK_DIV     = 4,
    parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 13'h0403,
    localparam int                 AW          = (TOTAL_PADS > 1) ? $clog2(TOTAL_PADS) : 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wdata,
    output logic [CFG_BITS-1:0] cfg_rdata,
    input  logic                xfer_start,
    output logic                xfer_busy,
    output logic                xfer_done,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_resetn,
    output logic                serial_data_1,
    output logic                serial_data_2
);

    localparam int N1     = AREA1PADS;
    localparam int N2     = TOTAL_PADS - AREA1PADS;
    localparam int MAXLEN = ((N1 > N2) ? N1 : N2) * CFG_BITS;
    localparam int HALF   = CLK_DIV / 2;
    localparam int DW     = $clog2(CLK_DIV);
    localparam int BW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam logic [AW:0] NPADS = (AW+1)'(TOTAL_PADS);

    typedef enum logic [2:0] {IDLE, CHAIN_RST, SHIFT, LOAD, DONE} state_t;

    logic [TOTAL_PADS-1:0][CFG_BITS-1:0] cfg_mem;
    logic addr_ok, wr_en;

    assign addr_ok = {1'b0, cfg_addr} < NPADS;
    assign wr_en   = cfg_we && addr_ok && !xfer_busy;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            cfg_mem <= {TOTAL_PADS{DEFAULT_CFG}};
        else if (wr_en)
            cfg_mem[cfg_addr] <= cfg_wdata;
    end

    // Write data is forwarded so a write is readable on the very next cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            cfg_rdata <= '0;
        else if (wr_en)
            cfg_rdata <= cfg_wdata;
        else if (addr_ok)
            cfg_rdata <= cfg_mem[cfg_addr];
        else
            cfg_rdata <= '0;
    end

    // Chain images, MSB sent first; unused upper bits form the leading-zero padding.
    logic [MAXLEN-1:0] img1, img2, sr1, sr2;

    always_comb begin
        img1 = '0;
        img2 = '0;
        for (int k = 0; k < N1; k++)
            img1[k*CFG_BITS +: CFG_BITS] = cfg_mem[k];
        for (int k = 0; k < N2; k++)
            img2[(N2-1-k)*CFG_BITS +: CFG_BITS] = cfg_mem[N1+k];
    end

    state_t        state;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [BW-1:0] bit_cnt;
    logic          div_last;

    assign div_last = div_cnt == DW'(CLK_DIV-1);
    assign div_nxt  = div_last ? '0 : div_cnt + DW'(1);

    // Outputs are assigned for the state being entered, so they line up with it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            sr1           <= '0;
            sr2           <= '0;
            xfer_busy     <= 1'b0;
            xfer_done     <= 1'b0;
            serial_clock  <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b0;
            serial_data_1 <= 1'b0;
            serial_data_2 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    xfer_done     <= 1'b0;
                    serial_clock  <= 1'b0;
                    serial_load   <= 1'b0;
                    serial_data_1 <= 1'b0;
                    serial_data_2 <= 1'b0;
                    serial_resetn <= !xfer_start;
                    xfer_busy     <= xfer_start;
                    div_cnt       <= '0;
                    bit_cnt       <= '0;
                    if (xfer_start) begin
                        state <= CHAIN_RST;
                        sr1   <= img1;
                        sr2   <= img2;
                    end
                end
                CHAIN_RST: begin
                    div_cnt <= div_nxt;
                    if (div_last) begin
                        state         <= SHIFT;
                        serial_resetn <= 1'b1;
                        serial_data_1 <= sr1[MAXLEN-1];
                        serial_data_2 <= sr2[MAXLEN-1];
                        sr1           <= sr1 << 1;
                        sr2           <= sr2 << 1;
                        bit_cnt       <= '0;
                    end
                end
                SHIFT: begin
                    div_cnt      <= div_nxt;
                    serial_clock <= div_nxt >= DW'(HALF);
                    if (div_last) begin
                        if (bit_cnt == BW'(MAXLEN-1)) begin
                            state         <= LOAD;
                            serial_load   <= 1'b1;
                            serial_clock  <= 1'b0;
                            serial_data_1 <= 1'b0;
                            serial_data_2 <= 1'b0;
                        end else begin
                            bit_cnt       <= bit_cnt + BW'(1);
                            serial_data_1 <= sr1[MAXLEN-1];
                            serial_data_2 <= sr2[MAXLEN-1];
                            sr1           <= sr1 << 1;
                            sr2           <= sr2 << 1;
                        end
                    end
                end
                LOAD: begin
                    div_cnt <= div_nxt;
                    if (div_last) begin
                        state       <= DONE;
                        serial_load <= 1'b0;
                        xfer_busy   <= 1'b0;
                        xfer_done   <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    xfer_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pad_config_loader.sv
// Directed bench for pad_config_loader: a timeline model derived from the transfer
// rules is compared every cycle, plus literal checks that pin the model.
module tb_pad_config_loader;

    localparam int A1 = 14, TP = 27, CB = 13, CD = 4;
    localparam int ML = 182;
    localparam int BUSY_END = (ML + 2) * CD;
    localparam int DONE_T = BUSY_END + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, we = 1'b0, start = 1'b0;
    logic [4:0]    addr = '0;
    logic [CB-1:0] wdata = '0;
    logic [CB-1:0] rdata;
    logic busy, done, sclk, sload, srstn, d1, d2;

    logic          we2 = 1'b0, start2 = 1'b0;
    logic [4:0]    addr2 = '0;
    logic [CB-1:0] wdata2 = '0;
    logic [CB-1:0] rdata2;
    logic busy2, done2, sclk2, sload2, srstn2, d21, d22;

    pad_config_loader dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(we), .cfg_addr(addr), .cfg_wdata(wdata),
        .cfg_rdata(rdata), .xfer_start(start), .xfer_busy(busy), .xfer_done(done),
        .serial_clock(sclk), .serial_load(sload), .serial_resetn(srstn),
        .serial_data_1(d1), .serial_data_2(d2)
    );

    pad_config_loader #(.AREA1PADS(10), .TOTAL_PADS(20), .CFG_BITS(13), .CLK_DIV(2)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(we2), .cfg_addr(addr2), .cfg_wdata(wdata2),
        .cfg_rdata(rdata2), .xfer_start(start2), .xfer_busy(busy2), .xfer_done(done2),
        .serial_clock(sclk2), .serial_load(sload2), .serial_resetn(srstn2),
        .serial_data_1(d21), .serial_data_2(d22)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: t counts cycles since start was sampled (0 = idle).
    logic [CB-1:0] mem [TP];
    logic          s1 [ML];
    logic          s2 [ML];
    logic [CB-1:0] m_rdata = '0;
    logic          m_rst = 1'b1, model_valid = 1'b0, busy_now, wr_ok;
    int            t = 0;

    always @(posedge clk) begin
        model_valid = 1'b1;
        if (rst) begin
            t = 0;
            m_rst = 1'b1;
            m_rdata = '0;
            for (int i = 0; i < TP; i++) mem[i] = 13'h0403;
        end else begin
            m_rst = 1'b0;
            busy_now = (t >= 1) && (t <= BUSY_END);
            wr_ok = we && (int'(addr) < TP) && !busy_now;
            if (int'(addr) < TP) m_rdata = wr_ok ? wdata : mem[addr];
            else m_rdata = '0;
            if (t == DONE_T) t = 0;
            else if (t > 0) t++;
            else if (start) begin
                t = 1;
                for (int b = 0; b < ML; b++) begin
                    int j1, j2;
                    j1 = b - (ML - A1 * CB);
                    j2 = b - (ML - (TP - A1) * CB);
                    s1[b] = (j1 < 0) ? 1'b0 : mem[A1 - 1 - j1 / CB][CB - 1 - j1 % CB];
                    s2[b] = (j2 < 0) ? 1'b0 : mem[A1 + j2 / CB][CB - 1 - j2 % CB];
                end
            end
            if (wr_ok) mem[addr] = wdata;
        end
    end

    // ctl order: busy, done, serial_clock, serial_load, serial_resetn, data_1, data_2
    logic [6:0] e_ctl, m_ctl, a_ctl;
    int s;
    always @(negedge clk) begin
        if (model_valid) begin
            m_ctl = 7'h7f;
            if (m_rst) e_ctl = 7'b0000000;
            else if (t == 0) e_ctl = 7'b0000100;
            else if (t <= CD) e_ctl = 7'b1000000;
            else if (t <= CD + ML * CD) begin
                s = t - CD - 1;
                e_ctl = {2'b10, ((s % CD) >= CD / 2), 2'b01, s1[s / CD], s2[s / CD]};
            end else if (t <= BUSY_END) begin
                e_ctl = 7'b1001100;
                m_ctl = 7'b1111100;
            end else e_ctl = 7'b0100100;
            a_ctl = {busy, done, sclk, sload, srstn, d1, d2};
            checks++;
            if ((((a_ctl ^ e_ctl) & m_ctl) != 7'd0) || (rdata !== m_rdata)) begin
                errors++;
                $display("FAIL cycle t=%0d ctl got %b want %b rdata got %h want %h",
                         t, a_ctl, e_ctl, rdata, m_rdata);
            end
        end
    end

    // Event monitor
    int cyc = 0, busy_cnt = 0, busy_rise = 0, done_cnt = 0, load_cnt = 0, sclk_rise = 0;
    int busy2_cnt = 0, sclk2_rise = 0, done2_cnt = 0, load2_cnt = 0;
    logic pb = 1'b0, ps = 1'b0, ps2 = 1'b0;
    logic q1[$], q2[$], q21[$], q22[$];
    int done_cyc[$], rise_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (busy && !pb) begin busy_rise++; rise_cyc.push_back(cyc); end
        if (done) begin done_cnt++; done_cyc.push_back(cyc); end
        if (sload) load_cnt++;
        if (sclk && !ps) begin sclk_rise++; q1.push_back(d1); q2.push_back(d2); end
        if (busy2) busy2_cnt++;
        if (done2) done2_cnt++;
        if (sload2) load2_cnt++;
        if (sclk2 && !ps2) begin sclk2_rise++; q21.push_back(d21); q22.push_back(d22); end
        pb = busy; ps = sclk; ps2 = sclk2;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    int b_busy, b_rise, b_done, b_load, b_q, b_dc, b_rc, b_b2, b_r2, b_q2, b_d2, b_l2;
    logic [31:0] v;

    initial begin
        // reset
        tick(2);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_resetn", {31'd0, srstn}, 0);
        chk("reset_resetn2", {31'd0, srstn2}, 0);
        chk("reset_rdata", {19'd0, rdata}, 0);
        rst = 1'b0;
        addr = 5'd0;
        tick(1);
        chk("resetn_rise", {31'd0, srstn}, 1);
        chk("default_pad0", {19'd0, rdata}, 32'h0403);

        // single default transfer
        b_busy = busy_cnt; b_rise = sclk_rise; b_done = done_cnt; b_load = load_cnt;
        pulse_start();
        tick(760);
        chk("busy_cycles", busy_cnt - b_busy, 736);
        chk("done_pulses", done_cnt - b_done, 1);
        chk("sclk_rises", sclk_rise - b_rise, 182);
        chk("load_cycles", load_cnt - b_load, 4);

        // pattern transfer
        we = 1'b1; addr = 5'd0; wdata = 13'h1FFF;
        tick(1);
        addr = 5'd26; wdata = 13'h1555;
        tick(1);
        we = 1'b0;
        chk("readback_26", {19'd0, rdata}, 32'h1555);
        b_q = q1.size();
        pulse_start();
        tick(760);
        chk("pattern_bits", q1.size() - b_q, 182);
        v = 0; for (int i = q1.size() - 13; i < q1.size(); i++) v = {v[30:0], q1[i]};
        chk("chain1_last_word", v, 32'h1FFF);
        v = 0; for (int i = q2.size() - 13; i < q2.size(); i++) v = {v[30:0], q2[i]};
        chk("chain2_last_word", v, 32'h1555);
        v = 0; for (int i = b_q; i < b_q + 13; i++) v = {v[30:0], q2[i]};
        chk("chain2_padding", v, 0);
        v = 0; for (int i = b_q; i < b_q + 13; i++) v = {v[30:0], q1[i]};
        chk("chain1_first_word", v, 32'h0403);

        // write while busy is dropped
        pulse_start();
        tick(50);
        we = 1'b1; addr = 5'd5; wdata = 13'h0AAA;
        tick(1);
        we = 1'b0;
        tick(720);
        addr = 5'd5;
        tick(1);
        chk("busy_write_dropped", {19'd0, rdata}, 32'h0403);
        addr = 5'd30;
        tick(1);
        chk("out_of_range_read", {19'd0, rdata}, 0);

        // start held high
        b_done = done_cnt; b_rise = busy_rise; b_dc = done_cyc.size(); b_rc = rise_cyc.size();
        start = 1'b1;
        tick(800);
        start = 1'b0;
        tick(800);
        chk("held_start_transfers", busy_rise - b_rise, 2);
        chk("held_start_dones", done_cnt - b_done, 2);
        chk("restart_gap", rise_cyc[b_rc + 1] - done_cyc[b_dc], 2);

        // reset in mid-shift (bit 90)
        b_rise = sclk_rise;
        pulse_start();
        tick(364);
        chk("pre_reset_bits", sclk_rise - b_rise, 90);
        chk("pre_reset_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        tick(1);
        chk("mid_reset_busy", {31'd0, busy}, 0);
        chk("mid_reset_resetn", {31'd0, srstn}, 0);
        chk("mid_reset_clock", {31'd0, sclk}, 0);
        rst = 1'b0;
        addr = 5'd0;
        tick(1);
        chk("pad0_after_reset", {19'd0, rdata}, 32'h0403);

        // balanced chains, CLK_DIV=2
        we2 = 1'b1; addr2 = 5'd9; wdata2 = 13'h1FFF;
        tick(1);
        addr2 = 5'd10;
        tick(1);
        we2 = 1'b0; addr2 = 5'd9;
        tick(1);
        chk("u2_readback_9", {19'd0, rdata2}, 32'h1FFF);
        b_b2 = busy2_cnt; b_r2 = sclk2_rise; b_q2 = q21.size(); b_d2 = done2_cnt; b_l2 = load2_cnt;
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        tick(300);
        chk("u2_busy_cycles", busy2_cnt - b_b2, 264);
        chk("u2_sclk_rises", sclk2_rise - b_r2, 130);
        chk("u2_done", done2_cnt - b_d2, 1);
        chk("u2_load", load2_cnt - b_l2, 2);
        chk("u2_chain1_first", {31'd0, q21[b_q2]}, 1);
        chk("u2_chain2_first", {31'd0, q22[b_q2]}, 1);
        chk("u2_resetn_idle", {31'd0, srstn2}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
